// File: rtl/present_key_scheduler_pkg.sv
// Shared PRESENT constants, scheduler state encoding and the 4-bit S-box.
// Width macros are defined here once so every later file sees the same build.
`ifndef PRESENT_CONSTANTS_SV
`define PRESENT_CONSTANTS_SV
`ifdef KEY_128
`define PRESENT_KEY_SIZE 128
`else
`define PRESENT_KEY_SIZE 80
`endif
`define PRESENT_NUM_ROUNDS 31
`endif

package present_key_scheduler_pkg;

  localparam int RK_W               = 64;
  localparam int KEY_SIZE_DEFAULT   = `PRESENT_KEY_SIZE;
  localparam int NUM_ROUNDS_DEFAULT = `PRESENT_NUM_ROUNDS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ksched_state_t;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_scheduler_update.sv
// Single-round PRESENT key register update (rotate, S-box, counter XOR)
// for either the 80-bit or the 128-bit key variant.
module present_key_update
  import present_key_scheduler_pkg::*;
#(
  parameter int KEY_SIZE = `PRESENT_KEY_SIZE
) (
  input  logic [KEY_SIZE-1:0] key,
  input  logic [4:0]          round,
  output logic [KEY_SIZE-1:0] next_key
);

  logic [KEY_SIZE-1:0] rot_s;

  // Rotate left by 61 == rotate right by KEY_SIZE-61.
  assign rot_s = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};

  if (KEY_SIZE == 128) begin : g_k128
    // Two S-boxes on the top byte, round counter folded into bits 66:62.
    always_comb begin
      next_key          = rot_s;
      next_key[127:124] = present_sbox(rot_s[127:124]);
      next_key[123:120] = present_sbox(rot_s[123:120]);
      next_key[66:62]   = rot_s[66:62] ^ round;
    end
  end else begin : g_k80
    // One S-box on the top nibble, round counter folded into bits 19:15.
    always_comb begin
      next_key        = rot_s;
      next_key[79:76] = present_sbox(rot_s[79:76]);
      next_key[19:15] = rot_s[19:15] ^ round;
    end
  end

endmodule

// File: rtl/present_key_scheduler.sv
// PRESENT key schedule sequencer: accepts a master key, expands all round
// keys into a 32-entry buffer one per clock, and serves registered reads.
module present_key_scheduler
  import present_key_scheduler_pkg::*;
#(
  parameter int KEY_SIZE   = `PRESENT_KEY_SIZE,
  parameter int NUM_ROUNDS = `PRESENT_NUM_ROUNDS,
  parameter int RK_W       = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                busy,
  output logic                keys_valid,
  input  logic                rk_rd_en,
  input  logic [4:0]          rk_addr,
  output logic [RK_W-1:0]     rk_data,
  output logic                rk_rd_valid
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  ksched_state_t       state_q, state_d;
  logic [4:0]          counter_q, counter_d;
  logic [KEY_SIZE-1:0] key_reg_q, key_reg_d;
  logic                keys_valid_q, keys_valid_d;
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;
  logic [RK_W-1:0]     rk_data_q, rk_data_d;
  logic                rk_rd_valid_q, rk_rd_valid_d;

  logic [KEY_SIZE-1:0] next_key_s;
  logic                wr_en_s;
  logic [4:0]          wr_addr_s;
  logic [RK_W-1:0]     wr_data_s;

  logic [RK_W-1:0]     rk_mem_q [0:NUM_ROUNDS];

  present_key_update #(
    .KEY_SIZE (KEY_SIZE)
  ) u_update (
    .key      (key_reg_q),
    .round    (counter_q),
    .next_key (next_key_s)
  );

  // Next-state, counter, key register and buffer write-port control.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    key_reg_d    = key_reg_q;
    keys_valid_d = keys_valid_q;
    wr_en_s      = 1'b0;
    wr_addr_s    = counter_q;
    wr_data_s    = next_key_s[KEY_SIZE-1 -: RK_W];
    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          key_reg_d    = key_in;
          counter_d    = 5'd1;
          state_d      = EXPAND;
          keys_valid_d = 1'b0;
          wr_en_s      = 1'b1;
          wr_addr_s    = 5'd0;
          wr_data_s    = key_in[KEY_SIZE-1 -: RK_W];
        end else begin
          state_d = state_q;
        end
      end
      EXPAND: begin
        key_reg_d = next_key_s;
        wr_en_s   = 1'b1;
        if (counter_q == LAST_ROUND) begin
          state_d      = READY;
          counter_d    = 5'd0;
          keys_valid_d = 1'b1;
        end else begin
          counter_d = counter_q + 5'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = 5'd0;
      end
    endcase
    key_ready_d = (state_d != EXPAND);
    busy_d      = (state_d == EXPAND);
  end

  // Read port: data is held between requests, valid is a one-cycle pulse.
  always_comb begin
    rk_rd_valid_d = rk_rd_en;
    if (rk_rd_en) begin
      rk_data_d = rk_mem_q[rk_addr];
    end else begin
      rk_data_d = rk_data_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      counter_q     <= 5'd0;
      key_reg_q     <= '0;
      keys_valid_q  <= 1'b0;
      key_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rk_data_q     <= '0;
      rk_rd_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      key_reg_q     <= key_reg_d;
      keys_valid_q  <= keys_valid_d;
      key_ready_q   <= key_ready_d;
      busy_q        <= busy_d;
      rk_data_q     <= rk_data_d;
      rk_rd_valid_q <= rk_rd_valid_d;
    end
  end

  // Round-key buffer; deliberately not reset, stale contents are gated by keys_valid.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      rk_mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign key_ready   = key_ready_q;
  assign busy        = busy_q;
  assign keys_valid  = keys_valid_q;
  assign rk_data     = rk_data_q;
  assign rk_rd_valid = rk_rd_valid_q;

endmodule

// File: tb/tb_present_key_scheduler.sv
// Directed self-checking bench for present_key_scheduler: an 80-bit and a
// 128-bit instance share clock and reset.
module tb_present_key_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [79:0]  a_key_in;
  logic         a_key_valid, a_key_ready, a_busy, a_keys_valid;
  logic         a_rd_en, a_rd_valid;
  logic [4:0]   a_addr;
  logic [63:0]  a_rk_data;

  logic [127:0] b_key_in;
  logic         b_key_valid, b_key_ready, b_busy, b_keys_valid;
  logic         b_rd_en, b_rd_valid;
  logic [4:0]   b_addr;
  logic [63:0]  b_rk_data;

  present_key_scheduler #(.KEY_SIZE(80), .NUM_ROUNDS(31), .RK_W(64)) dut80 (
    .clk(clk), .rst(rst), .key_in(a_key_in), .key_valid(a_key_valid),
    .key_ready(a_key_ready), .busy(a_busy), .keys_valid(a_keys_valid),
    .rk_rd_en(a_rd_en), .rk_addr(a_addr), .rk_data(a_rk_data),
    .rk_rd_valid(a_rd_valid)
  );

  present_key_scheduler #(.KEY_SIZE(128), .NUM_ROUNDS(31), .RK_W(64)) dut128 (
    .clk(clk), .rst(rst), .key_in(b_key_in), .key_valid(b_key_valid),
    .key_ready(b_key_ready), .busy(b_busy), .keys_valid(b_keys_valid),
    .rk_rd_en(b_rd_en), .rk_addr(b_addr), .rk_data(b_rk_data),
    .rk_rd_valid(b_rd_valid)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp80  [32];
  logic [63:0] exp128 [32];

  localparam logic [79:0] K1 = 80'h0123456789ABCDEF1357;
  localparam logic [79:0] K2 = 80'hFEDCBA98765432102468;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] tab;
    int i;
    tab = 64'hC56B90AD3EF84712;
    i = int'(x);
    return tab[63-4*i -: 4];
  endfunction

  task automatic model80(input logic [79:0] k0);
    logic [79:0] k;
    k = k0;
    exp80[0] = k[79:16];
    for (int r = 1; r < 32; r++) begin
      k = (k << 61) | (k >> 19);
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
      exp80[r] = k[79:16];
    end
  endtask

  task automatic model128(input logic [127:0] k0);
    logic [127:0] k;
    k = k0;
    exp128[0] = k[127:64];
    for (int r = 1; r < 32; r++) begin
      k = (k << 61) | (k >> 67);
      k[127:124] = sb(k[127:124]);
      k[123:120] = sb(k[123:120]);
      k[66:62] = k[66:62] ^ 5'(r);
      exp128[r] = k[127:64];
    end
  endtask

  task automatic load_a(input logic [79:0] k);
    a_key_in = k;
    a_key_valid = 1'b1;
    tick;
    a_key_valid = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!a_keys_valid && n < 100) begin
      tick;
      n++;
    end
  endtask

  task automatic read_a(input logic [4:0] addr);
    a_rd_en = 1'b1;
    a_addr = addr;
    tick;
    a_rd_en = 1'b0;
  endtask

  task automatic stream_a(input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      a_rd_en = 1'b1;
      a_addr = 5'(31 - i);
      tick;
      if (a_rd_valid) pulses++;
      check(tag, a_rk_data, exp80[31-i]);
    end
    a_rd_en = 1'b0;
    check({tag, "_pulses"}, 64'(pulses), 64'd32);
    tick;
    check({tag, "_valid_low"}, 64'(a_rd_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] old5;
    rst = 1'b1;
    a_key_in = '0; a_key_valid = 1'b0; a_rd_en = 1'b0; a_addr = '0;
    b_key_in = '0; b_key_valid = 1'b0; b_rd_en = 1'b0; b_addr = '0;
    tick; tick;
    rst = 1'b0;
    repeat (5) tick;
    check("rst_key_ready", 64'(a_key_ready), 64'd1);
    check("rst_keys_valid", 64'(a_keys_valid), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_rk_data", a_rk_data, 64'd0);
    check("rst_rd_valid", 64'(a_rd_valid), 64'd0);

    // 80-bit zero key, hand-computed round keys 0..2
    load_a(80'd0);
    check("exp_busy", 64'(a_busy), 64'd1);
    check("exp_ready_low", 64'(a_key_ready), 64'd0);
    wait_a(n);
    check("kv_latency", 64'(n), 64'd31);
    check("ready_after", 64'(a_key_ready), 64'd1);
    check("busy_after", 64'(a_busy), 64'd0);
    read_a(5'd0);
    check("z_rk0", a_rk_data, 64'h0000000000000000);
    check("z_rk0_valid", 64'(a_rd_valid), 64'd1);
    read_a(5'd1);
    check("z_rk1", a_rk_data, 64'hC000000000000000);
    read_a(5'd2);
    check("z_rk2", a_rk_data, 64'h5000180000000001);
    tick;
    check("z_valid_pulse", 64'(a_rd_valid), 64'd0);
    check("z_data_hold", a_rk_data, 64'h5000180000000001);

    // all-ones key, full schedule streamed 31..0
    model80('1);
    load_a('1);
    wait_a(n);
    check("ones_latency", 64'(n), 64'd31);
    stream_a("ones_rk");

    // second key held during EXPAND is not taken until READY
    model80(K1);
    load_a(K1);
    tick; tick; tick;
    a_key_in = K2;
    a_key_valid = 1'b1;
    check("hold_ready_low", 64'(a_key_ready), 64'd0);
    wait_a(n);
    check("hold_latency", 64'(n), 64'd28);
    check("hold_ready_high", 64'(a_key_ready), 64'd1);
    a_rd_en = 1'b1;
    a_addr = 5'd31;
    tick;
    a_key_valid = 1'b0;
    a_rd_en = 1'b0;
    check("hold_k1_rk31", a_rk_data, exp80[31]);
    check("hold_kv_drop", 64'(a_keys_valid), 64'd0);
    check("hold_busy", 64'(a_busy), 64'd1);
    model80(K2);
    wait_a(n);
    check("k2_latency", 64'(n), 64'd31);
    read_a(5'd0);
    check("k2_rk0", a_rk_data, K2[79:16]);
    read_a(5'd31);
    check("k2_rk31", a_rk_data, exp80[31]);

    // reset during expansion, then reload
    load_a(K1);
    repeat (14) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_ready", 64'(a_key_ready), 64'd1);
    check("mid_rst_kv", 64'(a_keys_valid), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_data", a_rk_data, 64'd0);
    tick;
    check("mid_rst_idle", 64'(a_busy), 64'd0);
    model80(K1);
    load_a(K1);
    wait_a(n);
    check("reload_latency", 64'(n), 64'd31);
    stream_a("reload_rk");

    // read of rk[5] on the edge that overwrites it returns the old value
    old5 = exp80[5];
    load_a(K2);
    repeat (4) tick;
    read_a(5'd5);
    check("rdw_old", a_rk_data, old5);
    wait_a(n);
    model80(K2);
    read_a(5'd5);
    check("rdw_new", a_rk_data, exp80[5]);

    // 128-bit instance, zero key
    model128(128'd0);
    b_key_in = '0;
    b_key_valid = 1'b1;
    tick;
    b_key_valid = 1'b0;
    n = 0;
    while (!b_keys_valid && n < 100) begin
      tick;
      n++;
    end
    check("k128_latency", 64'(n), 64'd31);
    for (int i = 0; i < 32; i++) begin
      b_rd_en = 1'b1;
      b_addr = 5'(i);
      tick;
      check("k128_rk", b_rk_data, exp128[i]);
      if (i == 1) check("k128_rk1_hand", b_rk_data, 64'hCC00000000000000);
    end
    b_rd_en = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/present_key_scheduler.md
# present_key_scheduler

Sequencer for the PRESENT key schedule. It accepts one master key through a valid/ready handshake and iterates the single-round key update 31 times, one round per clock. All 32 round keys are stored in an internal buffer, which the cipher round datapath reads back by round index. The block sits between key loading and the encrypt/decrypt round engine. Decryption reads keys in reverse order, so the full expansion completes before `keys_valid` asserts.

## Interface
- `KEY_SIZE`, default `` `key_size `` (80, or 128 when `KEY_128` is defined): master key width.
- `NUM_ROUNDS`, default `` `num_rounds `` (31): number of update rounds; the buffer holds `NUM_ROUNDS+1` keys.
- `RK_W`, default 64: round-key width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in `KEY_SIZE`: master key.
- `key_valid` in 1: `key_in` is presented.
- `key_ready` out 1: the block can accept a key.
- `busy` out 1: expansion in progress.
- `keys_valid` out 1: the buffer holds the complete schedule for the last accepted key.
- `rk_rd_en` in 1: read request.
- `rk_addr` in 5: round-key index, 0..31.
- `rk_data` out `RK_W`: registered read data.
- `rk_rd_valid` out 1: `rk_data` is valid this cycle.

## Operation
- States are IDLE, EXPAND and READY. Reset forces IDLE.
- Reset values: `key_ready`=1, `busy`=0, `keys_valid`=0, `rk_data`=0, `rk_rd_valid`=0, round counter=0. Buffer contents are not cleared.
- `key_ready`=1 in IDLE and READY, and 0 in EXPAND.
- A key is accepted on an edge where `key_valid && key_ready`. On that edge:
  - `key_reg <= key_in`
  - `rk[0] <= key_in[KEY_SIZE-1 -: 64]`
  - counter <= 1
  - state <= EXPAND
  - `keys_valid` <= 0
- Each EXPAND edge:
  - `nk = update(key_reg, counter)`
  - `key_reg <= nk`
  - `rk[counter] <= nk[KEY_SIZE-1 -: 64]`
  - counter <= counter + 1
- On the EXPAND edge where counter==31: write `rk[31]`, set state <= READY and `keys_valid` <= 1. The counter then returns to 0.
- Update function for 80-bit keys:
  - rotate left 61
  - S-box on bits [79:76]
  - bits [19:15] ^= counter
- Update function for 128-bit keys:
  - rotate left 61
  - S-box on [127:124] and [123:120]
  - bits [66:62] ^= counter
- The counter is 5 bits and runs 1..31. It never wraps during expansion.
- `key_valid` during EXPAND is ignored, and the key is not latched; the requester holds it until `key_ready`.
- A new key accepted in READY restarts expansion. `keys_valid` falls on the accepting edge.
- Reads are always permitted.
  - `rk_data` returns the buffer content as it was before the same-edge write, so a read-during-write returns the old value.
  - Reads while `keys_valid`=0 return undefined-but-deterministic stale data. Consumers gate on `keys_valid`.
- Reset mid-EXPAND returns the block to IDLE with `keys_valid`=0. The partial buffer remains but is invalid.

## Timing
- Acceptance edge at cycle T. The update edges are T+1..T+31.
- `busy`=1 in cycles T+1..T+31.
- `keys_valid`=1 and `key_ready`=1 from cycle T+32.
- Back-to-back keys: next acceptance is possible at the earliest in cycle T+32, giving 32 cycles per key.
- Read latency is 1 cycle: `rk_rd_en` at cycle N gives `rk_data`/`rk_rd_valid` at cycle N+1. `rk_rd_valid` is a 1-cycle pulse per request.
- Reads are fully pipelined, one per cycle.

## Structure
- The shared constants package (`Constants.sv`) holds `key_size`, `num_rounds` and `KEY_128`.
- Add to that package: the `RK_W` constant, a `ksched_state_t` enum (IDLE/EXPAND/READY) and the PRESENT S-box function.
- One combinational sub-module, `present_key_update`, with ports (`key`, `round` → `next_key`), implements the update function for both widths. The scheduler instantiates it once.
- The buffer is a 32×64 register array with one write port and one synchronous read port.

## Test plan
- Reset, then idle 5 cycles → `key_ready`=1, `keys_valid`=0, `busy`=0, `rk_data`=0.
- 80-bit key 0, wait for `keys_valid`, read addresses 0 and 1 → 0x0000000000000000 and 0xC000000000000000. `keys_valid` rises exactly 31 edges after acceptance.
- 80-bit key all-ones, then 128-bit build with key 0 → all 32 keys match the reference model. 128-bit key 0 gives `rk[1]` = 0xCC00000000000000.
- Assert `key_valid` with a second key during EXPAND → `key_ready`=0 and no latch. The first schedule completes, then the second key is accepted at T+32 and `keys_valid` drops on that edge.
- Assert `rst` at update 15 → next cycle IDLE, `keys_valid`=0, `key_ready`=1. Re-load the same key → correct full schedule.
- Read `rk[5]` on the same edge it is written → old value returned. Stream reads 31 down to 0, one per cycle once `keys_valid` is set → 32 consecutive `rk_rd_valid` pulses with correct data.
